// File: rtl/mmio_fabric.sv
// Registered request/acknowledge interconnect between the CPU data port and one RAM slot plus NSLOTS MMIO pages.
// Adds per-slave wait states, a timeout watchdog and a sticky fault flag.
module mmio_fabric #(
   parameter int unsigned data_width = 8,
   parameter int unsigned addr_width = 8,
   parameter int unsigned PAGE_BITS  = 4,
   parameter int unsigned NSLOTS     = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req,
   input  logic                             we,
   input  logic                             mmio,
   input  logic [addr_width-1:0]            addr,
   input  logic [data_width-1:0]            din,
   output logic [data_width-1:0]            dout,
   output logic                             ack,
   output logic                             err,
   output logic                             fault,
   input  logic                             fault_clr,
   output logic [NSLOTS:0]                  s_sel,
   output logic                             s_we,
   output logic [addr_width-1:0]            s_addr,
   output logic [data_width-1:0]            s_din,
   input  logic [(NSLOTS+1)*data_width-1:0] s_rdata,
   input  logic [NSLOTS:0]                  s_ready
);

   localparam int unsigned PW   = addr_width - PAGE_BITS;
   localparam int unsigned NSEL = NSLOTS + 1;
   localparam int unsigned SW   = (NSEL > 1) ? $clog2(NSEL) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_slot;
   logic [7:0]      r_cnt;
   logic            r_we;

   logic [PW-1:0]          w_page;
   logic                   w_mapped;
   logic [SW-1:0]          w_slot;
   logic [data_width-1:0]  w_rdata;
   logic                   w_ready;

   // Page decode; RAM space always maps to slot 0
   assign w_page   = addr[addr_width-1:PAGE_BITS];
   assign w_mapped = !mmio || (32'(w_page) < NSLOTS);
   assign w_slot   = mmio ? (SW'(w_page) + SW'(1)) : '0;
   assign w_rdata  = s_rdata[32'(r_slot)*data_width +: data_width];
   assign w_ready  = s_ready[r_slot];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_slot  <= '0;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         dout    <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         fault   <= 1'b0;
         s_sel   <= '0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_din   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               ack <= 1'b0;
               err <= 1'b0;
               if (fault_clr) fault <= 1'b0;
               if (req) begin
                  r_we   <= we;
                  s_addr <= addr;
                  s_din  <= din;
                  r_cnt  <= '0;
                  r_slot <= w_slot;
                  if (w_mapped) begin
                     s_sel   <= NSEL'(1) << w_slot;
                     s_we    <= we;
                     r_state <= ST_ACCESS;
                  end else begin
                     ack     <= 1'b1;
                     err     <= 1'b1;
                     dout    <= '0;
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               if (fault_clr) fault <= 1'b0;
               // Ready is checked first so it wins on the final counted cycle
               if (w_ready) begin
                  if (!r_we) dout <= w_rdata;
                  ack     <= 1'b1;
                  err     <= 1'b0;
                  s_sel   <= '0;
                  s_we    <= 1'b0;
                  r_state <= ST_RESP;
               end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                  ack     <= 1'b1;
                  err     <= 1'b1;
                  dout    <= '0;
                  s_sel   <= '0;
                  s_we    <= 1'b0;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               ack <= 1'b0;
               err <= 1'b0;
               if (err)            fault <= 1'b1;
               else if (fault_clr) fault <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
